// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 command sequencer: FSM states,
// the transfer record, the power-up init ROM and the clear/home classifier.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT,
    ST_READY
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_req_t;

  localparam int LCD_INIT_LEN = 4;
  localparam int LCD_INIT_IW  = $clog2(LCD_INIT_LEN);

  // Function set 8-bit/2-line, display on, clear, entry mode increment.
  // Element 0 is sent first.
  localparam logic [LCD_INIT_LEN-1:0][7:0] LCD_INIT_CMD = {8'h06, 8'h01, 8'h0C, 8'h38};

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  function automatic logic lcd_is_clr_home(input lcd_req_t req);
    return !req.rs && (req.data[7:2] == 6'd0) && (req.data != 8'h00);
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter shared by every timed phase; it holds at zero
// and reports zero combinationally so a phase ends in the cycle it reaches 0.
module lcd_delay_cnt #(
  parameter int CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_cmd_ctrl.sv
// HD44780 bus sequencer: power-up wait, autonomous init, then one
// setup/EN-pulse/hold/execute-wait transfer per accepted command byte.
module lcd_cmd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_PWRUP = 750000,
  parameter int T_AS    = 4,
  parameter int T_EN    = 12,
  parameter int T_HOLD  = 4,
  parameter int T_EXEC  = 2000,
  parameter int T_CLR   = 82000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  input  logic       cmd_rs_i,
  input  logic [7:0] cmd_data_i,
  output logic       cmd_ready_o,
  output logic       init_done_o,
  output logic       lcd_on_o,
  output logic       lcd_rw_o,
  output logic       lcd_rs_o,
  output logic       lcd_en_o,
  output logic [7:0] lcd_data_o
);

  localparam int T_MAX0 = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
  localparam int T_MAX  = (T_MAX0 > T_EXEC) ? T_MAX0 : T_EXEC;
  localparam int CW     = $clog2(T_MAX + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t L_PWRUP = cnt_t'(T_PWRUP - 1);
  localparam cnt_t L_AS    = cnt_t'(T_AS - 1);
  localparam cnt_t L_EN    = cnt_t'(T_EN - 1);
  localparam cnt_t L_HOLD  = cnt_t'(T_HOLD - 1);
  localparam cnt_t L_EXEC  = cnt_t'(T_EXEC - 1);
  localparam cnt_t L_CLR   = cnt_t'(T_CLR - 1);

  if (T_PWRUP < 1 || T_AS < 1 || T_EN < 1 || T_HOLD < 1 || T_EXEC < 1 || T_CLR < 1) begin : g_param_chk
    $error("lcd_cmd_ctrl: every timing parameter must be >= 1");
  end

  lcd_state_e             state_q;
  lcd_req_t               xfer_q;
  logic [LCD_INIT_IW-1:0] init_idx_q;
  logic [LCD_INIT_IW-1:0] init_idx_nxt;
  logic                   init_done_q;
  logic                   ready_q;
  logic                   en_q;
  logic                   on_q;

  logic cnt_load;
  cnt_t cnt_val;
  logic cnt_zero;
  logic init_last;
  logic accept;

  assign init_last    = (init_idx_q == LCD_INIT_IW'(LCD_INIT_LEN - 1));
  assign init_idx_nxt = init_idx_q + LCD_INIT_IW'(1);
  assign accept       = cmd_valid_i && ready_q;

  lcd_delay_cnt #(.CW(CW)) u_delay (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  // Counter reload for the phase being entered on the next edge.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    unique case (state_q)
      ST_PWRUP: begin
        if (!on_q) begin
          cnt_load = 1'b1;
          cnt_val  = L_PWRUP;
        end else if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = L_AS;
        end
      end
      ST_SETUP: begin
        cnt_load = cnt_zero;
        cnt_val  = L_EN;
      end
      ST_PULSE: begin
        cnt_load = cnt_zero;
        cnt_val  = L_HOLD;
      end
      ST_HOLD: begin
        cnt_load = cnt_zero;
        cnt_val  = lcd_is_clr_home(xfer_q) ? L_CLR : L_EXEC;
      end
      ST_WAIT: begin
        cnt_load = cnt_zero && !init_done_q && !init_last;
        cnt_val  = L_AS;
      end
      ST_READY: begin
        cnt_load = accept;
        cnt_val  = L_AS;
      end
      default: begin
        cnt_load = 1'b0;
        cnt_val  = '0;
      end
    endcase
  end

  // The first cycle out of reset only raises power and arms the power-up wait,
  // so PWRUP spans exactly T_PWRUP cycles counted from that edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_PWRUP;
      xfer_q      <= '0;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
      en_q        <= 1'b0;
      on_q        <= 1'b0;
    end else begin
      unique case (state_q)
        ST_PWRUP: begin
          if (!on_q) begin
            on_q <= 1'b1;
          end else if (cnt_zero) begin
            state_q    <= ST_SETUP;
            init_idx_q <= '0;
            xfer_q     <= '{rs: 1'b0, data: LCD_INIT_CMD[0]};
          end
        end
        ST_SETUP: begin
          if (cnt_zero) begin
            state_q <= ST_PULSE;
            en_q    <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_zero) begin
            state_q <= ST_HOLD;
            en_q    <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (cnt_zero) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_zero) begin
            if (init_done_q || init_last) begin
              state_q     <= ST_READY;
              ready_q     <= 1'b1;
              init_done_q <= 1'b1;
            end else begin
              state_q    <= ST_SETUP;
              init_idx_q <= init_idx_nxt;
              xfer_q     <= '{rs: 1'b0, data: LCD_INIT_CMD[init_idx_nxt]};
            end
          end
        end
        ST_READY: begin
          if (accept) begin
            state_q <= ST_SETUP;
            ready_q <= 1'b0;
            xfer_q  <= '{rs: cmd_rs_i, data: cmd_data_i};
          end
        end
        default: begin
          state_q <= ST_PWRUP;
          ready_q <= 1'b0;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = ready_q;
  assign init_done_o = init_done_q;
  assign lcd_on_o    = on_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_rs_o    = xfer_q.rs;
  assign lcd_en_o    = en_q;
  assign lcd_data_o  = xfer_q.data;

endmodule

// File: tb/tb_lcd_cmd_ctrl.sv
// Randomized bench for lcd_cmd_ctrl: a cycle-timeline model predicts every
// output each cycle, plus literal checks of init, transfer and reset timing.
module tb_lcd_cmd_ctrl;

  localparam int P_PWRUP = 20;
  localparam int P_AS    = 2;
  localparam int P_EN    = 3;
  localparam int P_HOLD  = 2;
  localparam int P_EXEC  = 10;
  localparam int P_CLR   = 30;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_rs_i = 1'b0;
  logic [7:0] cmd_data_i = 8'h00;
  logic       cmd_ready_o, init_done_o, lcd_on_o, lcd_rw_o, lcd_rs_o, lcd_en_o;
  logic [7:0] lcd_data_o;

  lcd_cmd_ctrl #(
    .T_PWRUP (P_PWRUP),
    .T_AS    (P_AS),
    .T_EN    (P_EN),
    .T_HOLD  (P_HOLD),
    .T_EXEC  (P_EXEC),
    .T_CLR   (P_CLR)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_rs_i    (cmd_rs_i),
    .cmd_data_i  (cmd_data_i),
    .cmd_ready_o (cmd_ready_o),
    .init_done_o (init_done_o),
    .lcd_on_o    (lcd_on_o),
    .lcd_rw_o    (lcd_rw_o),
    .lcd_rs_o    (lcd_rs_o),
    .lcd_en_o    (lcd_en_o),
    .lcd_data_o  (lcd_data_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  // Timeline model: a transfer is (start cycle, length, rs, data); outputs
  // follow from the offset into the current transfer.
  int         cyc = -1;
  bit         m_busy = 0, m_ready = 0, m_done = 0, m_on = 0;
  int         m_xs = 0, m_xl = 0, m_ninit = 0;
  logic       m_rs = 1'b0;
  logic [7:0] m_dat = 8'h00;
  logic [7:0] init_rom [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  function automatic int xfer_len(input logic r, input logic [7:0] d);
    if (!r && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return P_AS + P_EN + P_HOLD + P_CLR;
    return P_AS + P_EN + P_HOLD + P_EXEC;
  endfunction

  task automatic m_start(input logic r, input logic [7:0] d);
    m_busy  = 1;
    m_xs    = cyc;
    m_xl    = xfer_len(r, d);
    m_rs    = r;
    m_dat   = d;
    m_ready = 0;
  endtask

  initial begin : model
    bit acc;
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        cyc = -1; m_busy = 0; m_ready = 0; m_done = 0; m_on = 0;
        m_rs = 1'b0; m_dat = 8'h00; m_ninit = 0;
      end else begin
        acc = m_ready && cmd_valid_i;
        cyc++;
        m_on = 1;
        if (acc) begin
          m_start(cmd_rs_i, cmd_data_i);
        end else if (cyc == P_PWRUP) begin
          m_start(1'b0, init_rom[0]);
          m_ninit = 1;
        end else if (m_busy && cyc == m_xs + m_xl) begin
          m_busy = 0;
          if (m_ninit < 4) begin
            m_start(1'b0, init_rom[m_ninit]);
            m_ninit++;
          end else begin
            m_ready = 1;
            m_done  = 1;
          end
        end
      end
    end
  end

  int         rise_cyc[$];
  logic [7:0] rise_dat[$];
  int         done_cyc = -1;
  bit         seen55 = 0;

  initial begin : compare
    logic        en_prev, done_prev, exp_en;
    logic [13:0] act, exp;
    en_prev = 1'b0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      exp_en = m_busy && (cyc - m_xs) >= P_AS && (cyc - m_xs) < P_AS + P_EN;
      act = {lcd_on_o, init_done_o, cmd_ready_o, lcd_en_o, lcd_rs_o, lcd_data_o, lcd_rw_o};
      exp = {m_on, m_done, m_ready, exp_en, m_rs, m_dat, 1'b0};
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL cycle_cmp cyc=%0d on/done/rdy/en/rs/data/rw got %h expected %h", cyc, act, exp);
      end
      if (lcd_en_o && !en_prev) begin
        rise_cyc.push_back(cyc);
        rise_dat.push_back(lcd_data_o);
      end
      if (init_done_o && !done_prev) done_cyc = cyc;
      if (lcd_data_o == 8'h55) seen55 = 1;
      en_prev = lcd_en_o;
      done_prev = init_done_o;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_ready(input int bound);
    int n = 0;
    while (!cmd_ready_o && n < bound) begin
      @(negedge clk_i);
      n++;
    end
    check("ready_wait", cmd_ready_o, 1);
  endtask

  // Called at a negedge with ready high; returns cycles spent not ready.
  task automatic send(input logic r, input logic [7:0] d, input bit poke,
                      output int busy, output int acc);
    cmd_valid_i = 1'b1;
    cmd_rs_i    = r;
    cmd_data_i  = d;
    acc         = cyc;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    busy = 0;
    while (!cmd_ready_o && busy < 500) begin
      busy++;
      @(negedge clk_i);
      if (poke && busy == 10) begin
        cmd_valid_i = 1'b1;
        cmd_rs_i    = 1'b1;
        cmd_data_i  = 8'h55;
      end else begin
        cmd_valid_i = 1'b0;
      end
    end
  endtask

  task automatic check_init(input string tag);
    int exp_rise [4] = '{22, 39, 56, 93};
    wait_ready(300);
    check({tag, "_ready_cycle"}, cyc, 108);
    check({tag, "_done_cycle"}, done_cyc, 108);
    check({tag, "_en_pulses"}, rise_cyc.size(), 4);
    for (int i = 0; i < 4 && i < rise_cyc.size(); i++) begin
      check({tag, "_en_cycle"}, rise_cyc[i], exp_rise[i]);
      check({tag, "_en_data"}, rise_dat[i], init_rom[i]);
    end
  endtask

  initial begin : watchdog
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : main
    int busy, k, n, gap;
    logic r;
    logic [7:0] d;

    repeat (3) @(negedge clk_i);
    check("reset_outputs",
          {lcd_on_o, init_done_o, cmd_ready_o, lcd_en_o, lcd_rs_o, lcd_data_o, lcd_rw_o}, 0);

    // Power-up and init, with an ignored request in the middle of it.
    rise_cyc.delete(); rise_dat.delete();
    rst_ni = 1'b1;
    repeat (50) @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_rs_i = 1'b1; cmd_data_i = 8'h55;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    check_init("init");

    // Single data write.
    rise_cyc.delete(); rise_dat.delete();
    send(1'b1, 8'h41, 1'b0, busy, k);
    check("data_busy", busy, 17);
    check("data_en_pulses", rise_cyc.size(), 1);
    if (rise_cyc.size() > 0) begin
      check("data_en_cycle", rise_cyc[0], k + 3);
      check("data_en_byte", rise_dat[0], 8'h41);
    end
    check("data_rs_retained", lcd_rs_o, 1);
    check("data_byte_retained", lcd_data_o, 8'h41);

    // Clear/home classification, with ignored requests while busy.
    rise_cyc.delete(); rise_dat.delete();
    send(1'b0, 8'h01, 1'b1, busy, k);
    check("clear_busy", busy, 37);
    send(1'b0, 8'h80, 1'b0, busy, k);
    check("ddram_addr_busy", busy, 17);
    send(1'b1, 8'h01, 1'b1, busy, k);
    check("data01_busy", busy, 17);
    check("clear_en_pulses", rise_cyc.size(), 3);
    check("ignored_55_never_shown", seen55, 0);

    // Back-to-back with valid held high.
    rise_cyc.delete(); rise_dat.delete();
    cmd_valid_i = 1'b1; cmd_rs_i = 1'b1; cmd_data_i = 8'h48;
    @(negedge clk_i);
    cmd_data_i = 8'h49;
    wait_ready(100);
    @(negedge clk_i);
    check("b2b_single_ready_cycle", cmd_ready_o, 0);
    cmd_valid_i = 1'b0;
    wait_ready(100);
    check("b2b_en_pulses", rise_cyc.size(), 2);
    if (rise_cyc.size() == 2) begin
      check("b2b_en_spacing", rise_cyc[1] - rise_cyc[0], 18);
      check("b2b_first_byte", rise_dat[0], 8'h48);
      check("b2b_second_byte", rise_dat[1], 8'h49);
    end

    // Randomized traffic; the per-cycle compare does the heavy lifting.
    for (int i = 0; i < 40; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk_i);
      r = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(0, 4));
      else d = 8'($urandom);
      send(r, d, ($urandom_range(0, 1) == 1), busy, k);
      check("rand_busy", busy, xfer_len(r, d));
    end

    // Asynchronous reset during an EN pulse, then a full re-init.
    cmd_valid_i = 1'b1; cmd_rs_i = 1'b1; cmd_data_i = 8'h5A;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    n = 0;
    while (!lcd_en_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("reached_pulse", lcd_en_o, 1);
    #2 rst_ni = 1'b0;
    #1 check("async_reset_outputs",
             {lcd_on_o, init_done_o, cmd_ready_o, lcd_en_o, lcd_rs_o, lcd_data_o}, 0);
    repeat (2) @(negedge clk_i);
    rise_cyc.delete(); rise_dat.delete();
    done_cyc = -1;
    rst_ni = 1'b1;
    check_init("reinit");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
